// File: rtl/tlp_arb_pkg.sv
// Shared constants for the TLP class arbiter: class count, index width, FSM encodings
// and the round-robin pointer reset value.
package tlp_arb_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int CLS_W       = 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Pointer parked on the last class so the first search after reset starts at class 0.
  localparam logic [CLS_W-1:0] RR_PTR_RST = 2'd3;

endpackage

// File: rtl/rr_grant4.sv
// Four-way grant: searches upward from rr_ptr+1 with wrap and holds rr_ptr.
// ARB_STRICT_PRIO_EN freezes the pointer at 3, which turns the search into fixed 0>1>2>3.
module rr_grant4
  import tlp_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLASSES-1:0] elig,
  output logic [NUM_CLASSES-1:0] grant,
  output logic                   grant_valid,
  output logic [CLS_W-1:0]       grant_idx
);

`ifdef ARB_STRICT_PRIO_EN
  localparam logic PTR_ADVANCE = 1'b0;
`else
  localparam logic PTR_ADVANCE = 1'b1;
`endif

  logic [CLS_W-1:0] rr_ptr;

  always_comb begin
    logic [CLS_W-1:0] cand;
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    // k = NUM_CLASSES wraps back to rr_ptr itself, so it is checked last.
    for (int k = 1; k <= NUM_CLASSES; k++) begin
      cand = rr_ptr + CLS_W'(k);
      if (!grant_valid && elig[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    grant = grant_valid ? (NUM_CLASSES'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= RR_PTR_RST;
    end else if (PTR_ADVANCE && grant_valid) begin
      rr_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/tlp_class_arbiter.sv
// Drains four class FIFOs into one downstream FIFO, tagging each word with its class.
// Build option ARB_STRICT_PRIO_EN (in rr_grant4) selects fixed priority instead of round-robin.
module tlp_class_arbiter
  import tlp_arb_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLASSES-1:0]        in_empty,
  input  logic [NUM_CLASSES-1:0]        in_almost_empty,
  input  logic [NUM_CLASSES-1:0]        in_error,
  input  logic [NUM_CLASSES*DATA_W-1:0] in_data,
  output logic [NUM_CLASSES-1:0]        in_pop,
  input  logic                          out_full,
  input  logic                          out_almost_full,
  output logic                          out_push,
  output logic [DATA_W-1:0]             out_data,
  output logic [CLS_W-1:0]              out_class,
  output logic                          err
);

  logic [0:0]             state;
  logic [NUM_CLASSES-1:0] last_pop;
  logic [NUM_CLASSES-1:0] elig;
  logic [NUM_CLASSES-1:0] grant;
  logic                   grant_valid;
  logic [CLS_W-1:0]       grant_idx;
  logic                   pop_ok;
  logic                   v1;
  logic [CLS_W-1:0]       sel_q;

  assign pop_ok = (state == ST_RUN) && !out_full && !out_almost_full;

  // Upstream flags lag a pop by a cycle: a class popped last cycle that reports
  // almost_empty may already be drained, so it sits out this cycle.
  assign elig   = pop_ok ? (~in_empty & (~last_pop | ~in_almost_empty)) : '0;
  assign in_pop = grant;

  rr_grant4 u_grant (
    .clk         (clk),
    .reset       (reset),
    .elig        (elig),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      err       <= 1'b0;
      last_pop  <= '0;
      v1        <= 1'b0;
      sel_q     <= '0;
      out_push  <= 1'b0;
      out_data  <= '0;
      out_class <= '0;
    end else begin
      if (state == ST_RUN && |in_error) begin
        state <= ST_HALT;
      end
      err      <= err | (|in_error);
      last_pop <= in_pop;
      v1       <= grant_valid;
      if (grant_valid) begin
        sel_q <= grant_idx;
      end
      // Words already popped still complete the pipeline after a halt.
      out_push <= v1;
      if (v1) begin
        out_data  <= in_data[int'(sel_q)*DATA_W +: DATA_W];
        out_class <= sel_q;
      end
    end
  end

endmodule
